// File: rtl/pool_layer_1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pool_layer_1
// Brief    : Streaming 2x2 / stride-2 signed max-pool over CHANNELS parallel
//            feature maps. One half-width line buffer holds the partial maxima
//            of the even row, so no full frame is ever stored.
// Options  : define POOL1_RELU_EN to clamp negative pooled results to zero
//            (fused ReLU) before they reach the output register.
// Revision : 1.0 - initial release
// ============================================================================
module pool_layer_1 #(
  parameter int BITWIDTH = 16,
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 28,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*BITWIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*BITWIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam int c_DW   = CHANNELS * BITWIDTH;
  localparam int c_HALF = WIDTH / 2;
  localparam int c_CW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int c_RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int c_LW   = (c_HALF > 1) ? $clog2(c_HALF) : 1;

  // Raster position of the next pixel to be accepted
  logic [c_CW-1:0] col_q, col_d;
  logic [c_RW-1:0] row_q, row_d;
  // Left pixel of the current horizontal pair
  logic [c_DW-1:0] hreg_q, hreg_d;
  // Output register
  logic            out_valid_q, out_valid_d;
  logic [c_DW-1:0] out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  // Partial (even-row) maxima, one entry per output column
  logic [c_DW-1:0] linebuf_q [c_HALF];

  logic            w_accept;
  logic            w_col_odd;
  logic            w_row_odd;
  logic            w_col_last;
  logic            w_row_last;
  logic            w_load;
  logic            w_lb_wr;
  logic [c_LW-1:0] w_lb_idx;
  logic [c_DW-1:0] w_lb_rd;
  logic [c_DW-1:0] w_pair;
  logic [c_DW-1:0] w_res;

  // The output register never gets overwritten: input stalls while it is full
  // and not draining, which stalls the whole stream.
  assign in_ready   = !out_valid_q || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_col_odd  = col_q[0];
  assign w_row_odd  = row_q[0];
  assign w_col_last = (col_q == c_CW'(WIDTH - 1));
  assign w_row_last = (row_q == c_RW'(HEIGHT - 1));
  assign w_load     = w_accept && w_col_odd && w_row_odd;
  assign w_lb_wr    = w_accept && w_col_odd && !w_row_odd;
  assign w_lb_idx   = c_LW'(col_q >> 1);
  assign w_lb_rd    = linebuf_q[w_lb_idx];

  // Per-channel signed comparison tree: pair max, then window max
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [BITWIDTH-1:0] w_in;
    logic signed [BITWIDTH-1:0] w_h;
    logic signed [BITWIDTH-1:0] w_lb;
    logic signed [BITWIDTH-1:0] w_pmax;
    logic signed [BITWIDTH-1:0] w_wmax;

    assign w_in   = $signed(in_data[c*BITWIDTH +: BITWIDTH]);
    assign w_h    = $signed(hreg_q[c*BITWIDTH +: BITWIDTH]);
    assign w_lb   = $signed(w_lb_rd[c*BITWIDTH +: BITWIDTH]);
    assign w_pmax = (w_in > w_h) ? w_in : w_h;
    assign w_wmax = (w_lb > w_pmax) ? w_lb : w_pmax;

    assign w_pair[c*BITWIDTH +: BITWIDTH] = w_pmax;
`ifdef POOL1_RELU_EN
    assign w_res[c*BITWIDTH +: BITWIDTH]  = w_wmax[BITWIDTH-1] ? '0 : w_wmax;
`else
    assign w_res[c*BITWIDTH +: BITWIDTH]  = w_wmax;
`endif
  end

  // Next-state: raster counters, pair register and output register
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hreg_d      = hreg_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (w_accept) begin
      if (!w_col_odd) begin
        hreg_d = in_data;
      end
      if (w_col_last) begin
        col_d = '0;
        row_d = w_row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // A fresh result takes priority over a simultaneous transfer
    if (w_load) begin
      out_valid_d = 1'b1;
      out_data_d  = w_res;
      out_last_d  = w_row_last && w_col_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hreg_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hreg_q      <= hreg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer write on odd columns of even rows; written before every read
  always_ff @(posedge clk) begin
    if (w_lb_wr) begin
      linebuf_q[w_lb_idx] <= w_pair;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_layer_1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pool_layer_1
// Brief    : Self-checking bench for pool_layer_1: ramp frames, a table of
//            tiled corner-case windows, backpressure, random traffic over
//            three frames and an asynchronous reset mid-frame.
// Options  : honours POOL1_RELU_EN for expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_layer_1;

  localparam int B   = 16;
  localparam int W   = 28;
  localparam int H   = 28;
  localparam int CH  = 2;
  localparam int DW  = CH * B;
  localparam int BND = 5000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;

  always #5 clk = ~clk;

  pool_layer_1 #(.BITWIDTH(B), .WIDTH(W), .HEIGHT(H), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    int win0[4];   // order: (even r, even c), (even r, odd c), (odd r, even c), (odd r, odd c)
    int win1[4];
    int exp0_raw;
    int exp1_raw;
    int exp0_relu;
    int exp1_relu;
  } vec_t;

  exp_t          exp_q[$];
  logic [DW-1:0] frame[H][W];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_last   = 0;
  bit            sb_off   = 1'b0;
  bit            rdy_rand = 1'b0;
  bit            bp_arm   = 1'b0;
  int            bp_left  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic logic [DW-1:0] pack2(input int a, input int b);
    logic [B-1:0] a16;
    logic [B-1:0] b16;
    a16 = a[B-1:0];
    b16 = b[B-1:0];
    return {b16, a16};
  endfunction

  // Reference 2x2 max-pool straight from the stored frame
  function automatic logic [DW-1:0] pool_win(input int r, input int c);
    logic [DW-1:0]       res;
    logic signed [B-1:0] m;
    logic signed [B-1:0] v;
    for (int ch = 0; ch < CH; ch++) begin
      m = $signed(frame[r][c][ch*B +: B]);
      for (int k = 1; k < 4; k++) begin
        v = $signed(frame[r + k/2][c + k%2][ch*B +: B]);
        if (v > m) m = v;
      end
`ifdef POOL1_RELU_EN
      if (m < 0) m = '0;
`endif
      res[ch*B +: B] = m;
    end
    return res;
  endfunction

  // Sole owner of out_ready: held high, random, or a 10-cycle backpressure burst
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = 1'($urandom_range(1, 0));
      else if (bp_arm && out_valid) begin
        out_ready = 1'b0;
        bp_left   = 10;
        bp_arm    = 1'b0;
      end else if (bp_left > 0) begin
        bp_left--;
        if (bp_left == 0) out_ready = 1'b1;
      end else out_ready = 1'b1;
    end
  end

  // Output monitor / scoreboard, sampled on the falling edge
  initial begin
    bit            stall_prev;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    exp_t          e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) stall_prev = 1'b0;
      else begin
        if (stall_prev) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_data", 64'(out_data), 64'(prev_data));
          chk("hold_last", 64'(out_last), 64'(prev_last));
        end
        if (out_valid && !out_ready) chk("in_ready_full", 64'(in_ready), 64'd0);
        if (out_valid && out_ready && !sb_off) begin
          if (out_last) n_last++;
          if (exp_q.size() == 0) chk("unexpected_out", 64'(out_data), 64'hDEAD_0000_0000);
          else begin
            e = exp_q.pop_front();
            chk("out_data", 64'(out_data), 64'(e.data));
            chk("out_last", 64'(out_last), 64'(e.last));
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  // Called and returns at posedge+1; holds the pixel until it is accepted
  task automatic send_px(input logic [DW-1:0] d, input bit gaps);
    int t;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < BND) begin
      @(negedge clk);
      t++;
    end
    if (t >= BND) chk("in_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_px(frame[r][c], gaps);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < BND) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic build_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = pack2(r*W + c, r*W + c);
  endtask

  // Closed-form ramp expectations, independent of the reference pool
  task automatic push_ramp_expect();
    int v;
    for (int k = 0; k < (H/2)*(W/2); k++) begin
      v = (2*(k/(W/2)) + 1)*W + 2*(k%(W/2)) + 1;
      exp_q.push_back('{pack2(v, v), (k == (H/2)*(W/2) - 1)});
    end
  endtask

  vec_t vecs[4];

  initial begin
    exp_t e;
    int   e0;
    int   e1;

    vecs[0] = '{'{-5, -3, -9, -7}, '{-1, -1, -1, -1}, -3, -1, 0, 0};
    vecs[1] = '{'{-32768, 32767, 0, -1}, '{-32768, -32768, -32768, -32768}, 32767, -32768, 32767, 0};
    vecs[2] = '{'{1, 2, 3, 4}, '{4, 3, 2, 1}, 4, 4, 4, 4};
    vecs[3] = '{'{7, -8, 7, -8}, '{-2, -2, 5, -3}, 7, 5, 7, 5};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean ramp frame, full throughput
    build_ramp();
    push_ramp_expect();
    n_last = 0;
    send_frame(1'b0);
    drain();
    chk("ramp_last_cnt", 64'(n_last), 64'd1);

    // Tiled corner-case windows: every window of the frame is the table window
    for (int i = 0; i < 4; i++) begin
`ifdef POOL1_RELU_EN
      e0 = vecs[i].exp0_relu;
      e1 = vecs[i].exp1_relu;
`else
      e0 = vecs[i].exp0_raw;
      e1 = vecs[i].exp1_raw;
`endif
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          frame[r][c] = pack2(vecs[i].win0[(r%2)*2 + c%2], vecs[i].win1[(r%2)*2 + c%2]);
      for (int k = 0; k < (H/2)*(W/2); k++) begin
        e.data = pack2(e0, e1);
        e.last = (k == (H/2)*(W/2) - 1);
        exp_q.push_back(e);
      end
      send_frame(1'b0);
      drain();
    end

    // Backpressure burst from the first out_valid
    build_ramp();
    push_ramp_expect();
    bp_arm = 1'b1;
    send_frame(1'b0);
    drain();

    // Three back-to-back random frames, random gaps and random out_ready
    rdy_rand = 1'b1;
    n_last   = 0;
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          frame[r][c] = pack2(int'($urandom_range(65535, 0)), int'($urandom_range(65535, 0)));
      for (int r = 0; r < H/2; r++)
        for (int c = 0; c < W/2; c++)
          exp_q.push_back('{pool_win(2*r, 2*c), (r == H/2-1 && c == W/2-1)});
      send_frame(1'b1);
    end
    drain();
    chk("rand_last_cnt", 64'(n_last), 64'd3);
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset after 100 accepted pixels, then a clean ramp
    sb_off = 1'b1;
    for (int p = 0; p < 100; p++)
      send_px(pack2(int'($urandom_range(65535, 0)), int'($urandom_range(65535, 0))), 1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
    end
    rst_n  = 1'b1;
    sb_off = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    build_ramp();
    push_ramp_expect();
    n_last = 0;
    send_frame(1'b0);
    drain();
    chk("post_rst_last_cnt", 64'(n_last), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
